seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It shares one `bcd_to_7seg_decoder` instance across `NUM_DIGITS` digits and drives one-hot digit enables with a blanking gap between digits to prevent ghosting. New display values arrive through a valid/ready load port and take effect only at frame boundaries, so a frame never shows a torn value. The block sits between the system value producer and the display pins.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/bcd_to_7seg_decoder.sv | 26 ++
 rtl/seven_seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Bit positions inside the {g,f,e,d,c,b,a} segment vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_to_7seg_decoder.sv
// Combinational BCD to active-high 7-segment decoder; non-BCD codes decode to all-off.
module bcd_to_7seg_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b0111111;
            4'd1: seg = 7'b0000110;
            4'd2: seg = 7'b1011011;
            4'd3: seg = 7'b1001111;
            4'd4: seg = 7'b1100110;
            4'd5: seg = 7'b1101101;
            4'd6: seg = 7'b1111101;
            4'd7: seg = 7'b0000111;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking gaps, frame-aligned value
// updates through a valid/ready load port, and leading-zero suppression.
module seven_seg_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [4*NUM_DIGITS-1:0] snap_bcd, snap_bcd_n, pend_bcd;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n, pend_dp;
    logic                    pend_full;
    logic                    boundary;

    logic [3:0]              nibble;
    logic                    dp_bit;
    logic                    lz_hit;
    logic                    zero_above;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_n;

    assign load_ready = !pend_full;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        boundary = (state == SHOW) && (idx == IDX_LAST) && (cnt == DWELL_LAST);
        if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_n = SHOW;
                cnt_n   = '0;
            end
        end else if (cnt == DWELL_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        snap_bcd_n = (boundary && pend_full) ? pend_bcd : snap_bcd;
        snap_dp_n  = (boundary && pend_full) ? pend_dp  : snap_dp;
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        nibble     = 4'd0;
        dp_bit     = 1'b0;
        lz_hit     = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (snap_bcd_n[4*i +: 4] == 4'd0);
            if (idx_n == IDX_W'(i)) begin
                nibble = snap_bcd_n[4*i +: 4];
                dp_bit = snap_dp_n[i];
                lz_hit = lz_blank_en && zero_above && (i != 0);
            end
        end
    end

    bcd_to_7seg_decoder u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    assign seg_n = ((state_n == SHOW) && (nibble <= BCD_MAX) && !lz_hit) ? dec_seg : SEG_BLANK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            snap_bcd   <= '0;
            snap_dp    <= '0;
            pend_full  <= 1'b0;
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            snap_bcd   <= snap_bcd_n;
            snap_dp    <= snap_dp_n;
            if (boundary && pend_full)
                pend_full <= 1'b0;
            else if (load_valid && !pend_full)
                pend_full <= 1'b1;
            seg_out    <= seg_n;
            dp_out     <= (state_n == SHOW) && dp_bit;
            digit_en   <= (state_n == SHOW) ? (NUM_DIGITS'(1) << idx_n) : '0;
            frame_done <= (state_n == SHOW) && (idx_n == IDX_LAST) && (cnt_n == DWELL_LAST);
        end
    end

    // Pending payload only matters while pend_full is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_valid && !pend_full) begin
            pend_bcd <= bcd_in;
            pend_dp  <= dp_in;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl against a frame-position reference model.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BW    = 2;
    localparam int SLOT  = BW + DW;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_blank_en = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_done;
    logic [13:0] obs;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .lz_blank_en (lz_blank_en),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    assign obs = {frame_done, load_ready, digit_en, dp_out, seg_out};

    // Reference model: position within the frame plus snapshot/pending values.
    int          m_pos = 0;
    logic [15:0] m_snap = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_sdp = '0;
    logic [3:0]  m_pdp = '0;
    logic        m_full = 1'b0;
    logic        m_lz = 1'b0;
    int          m_accepts = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_pos  = 0;
            m_snap = '0;
            m_sdp  = '0;
            m_full = 1'b0;
        end else begin
            if (load_valid && !m_full) begin
                m_pend = bcd_in;
                m_pdp  = dp_in;
                m_full = 1'b1;
                m_accepts++;
            end else if (m_full && m_pos == FRAME - 1) begin
                m_snap = m_pend;
                m_sdp  = m_pdp;
                m_full = 1'b0;
            end
            m_lz  = lz_blank_en;
            m_pos = (m_pos + 1) % FRAME;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F; default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic int cur_digit();
        return m_pos / SLOT;
    endfunction

    function automatic logic cur_show();
        return (m_pos % SLOT) >= BW;
    endfunction

    function automatic logic [13:0] exp_vec();
        int         d;
        logic       show;
        logic [3:0] nib;
        logic       lzb;
        logic [6:0] seg;
        logic [3:0] en;
        logic       dp;
        d    = cur_digit();
        show = cur_show();
        nib  = m_snap[4*d +: 4];
        lzb  = m_lz && (d != 0) && ((m_snap >> (4*d)) == 16'd0);
        seg  = (show && nib <= 4'd9 && !lzb) ? seg_of(nib) : 7'd0;
        en   = show ? 4'(1 << d) : 4'd0;
        dp   = show ? m_sdp[d] : 1'b0;
        return {(m_pos == FRAME - 1), !m_full, en, dp, seg};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (obs !== 14'b01_0000_0_0000000)
            $display("FAIL reset_init got=%b exp=%b", obs, 14'b01_0000_0_0000000);
        if (obs !== 14'b01_0000_0_0000000) errors++;
        repeat (7) @(negedge clk);
        load_valid = 1'b1;
        bcd_in     = 16'h9999;
        dp_in      = 4'hF;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending_full load_ready=%b exp=0", load_ready);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({seg_out, dp_out, digit_en, frame_done, load_ready} !== {7'd0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got seg=%b dp=%b en=%b fd=%b rdy=%b exp 0/0/0/0/1",
                     seg_out, dp_out, digit_en, frame_done, load_ready);
        end
    endtask

    task automatic test_scan_timing();
        for (int k = 1; k <= 2 * FRAME; k++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL scan_model k=%0d got=%b exp=%b", k, obs, exp_vec());
            end
            checks++;
            if (frame_done !== (k % FRAME == 0)) begin
                errors++;
                $display("FAIL scan_frame_done k=%0d got=%b exp=%b", k, frame_done, (k % FRAME == 0));
            end
            if (digit_en != 4'd0) begin
                checks++;
                if (seg_out !== 7'b0111111) begin
                    errors++;
                    $display("FAIL scan_seg_zero k=%0d got=%b exp=0111111", k, seg_out);
                end
            end
            @(negedge clk);
        end
    endtask

    // Loads a value, then checks every lit cycle of it against literal per-digit segments.
    task automatic test_display_case(input logic [15:0] v, input logic [3:0] d,
                                     input logic lz, input logic [27:0] segs);
        int acc0;
        int shown;
        int dg;
        acc0        = m_accepts;
        shown       = 0;
        lz_blank_en = lz;
        load_valid  = 1'b1;
        bcd_in      = v;
        dp_in       = d;
        for (int k = 0; k < 5 * FRAME; k++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL display_model v=%h k=%0d got=%b exp=%b", v, k, obs, exp_vec());
            end
            if (m_snap == v && m_sdp == d && cur_show()) begin
                dg = cur_digit();
                checks++;
                if (seg_out !== segs[7*dg +: 7] || dp_out !== d[dg] || digit_en !== 4'(1 << dg)) begin
                    errors++;
                    $display("FAIL display_literal v=%h digit=%0d got seg=%b dp=%b en=%b exp seg=%b dp=%b",
                             v, dg, seg_out, dp_out, digit_en, segs[7*dg +: 7], d[dg]);
                end
                shown++;
            end
            @(negedge clk);
            if (m_accepts != acc0) load_valid = 1'b0;
        end
        load_valid = 1'b0;
        checks++;
        if (shown < 16) begin
            errors++;
            $display("FAIL display_timeout v=%h shown_cycles=%0d exp>=16", v, shown);
        end
    endtask

    task automatic test_back_to_back();
        int   acc0;
        int   k;
        int   twos;
        logic fd1;
        logic fd2;
        logic done;
        acc0        = m_accepts;
        fd1         = 1'b0;
        fd2         = 1'b0;
        done        = 1'b0;
        k           = 0;
        lz_blank_en = 1'b0;
        load_valid  = 1'b1;
        bcd_in      = 16'h1111;
        dp_in       = 4'h0;
        while (!done && k < 6 * FRAME) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model k=%0d got=%b exp=%b", k, obs, exp_vec());
            end
            fd2 = fd1;
            fd1 = frame_done;
            @(negedge clk);
            k++;
            if (m_accepts == acc0 + 1 && bcd_in == 16'h1111) begin
                bcd_in = 16'h2222;
            end else if (m_accepts == acc0 + 2) begin
                load_valid = 1'b0;
                done       = 1'b1;
                checks++;
                if (fd2 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_accept_after_boundary fd_two_ago=%b exp=1", fd2);
                end
            end
        end
        load_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL b2b_timeout accepts=%0d exp=%0d", m_accepts - acc0, 2);
        end
        twos = 0;
        for (int j = 0; j < 3 * FRAME; j++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model_tail j=%0d got=%b exp=%b", j, obs, exp_vec());
            end
            if (digit_en != 4'd0 && seg_out == 7'b1011011) twos++;
            @(negedge clk);
        end
        checks++;
        if (twos == 0) begin
            errors++;
            $display("FAIL b2b_second_shown count=%0d exp>0", twos);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25 * FRAME; k++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_model k=%0d got=%b exp=%b", k, obs, exp_vec());
            end
            @(negedge clk);
            load_valid = ($urandom % 4) == 0;
            for (int n = 0; n < ND; n++)
                bcd_in[4*n +: 4] = (($urandom % 3) == 0) ? 4'd0 : 4'($urandom % 16);
            dp_in = 4'($urandom);
            if (($urandom % 8) == 0) lz_blank_en = ~lz_blank_en;
        end
        load_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_timing();
        test_display_case(16'h1234, 4'b0010, 1'b0,
                          {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110});
        test_display_case(16'h0050, 4'b0000, 1'b1,
                          {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111});
        test_display_case(16'h0000, 4'b0000, 1'b1,
                          {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111});
        test_display_case(16'h00A0, 4'b0000, 1'b0,
                          {7'b0111111, 7'b0111111, 7'b0000000, 7'b0111111});
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
